// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter with a bounded hold time per grant.
// Every release leaves one idle cycle. The release also advances the priority pointer past the owner.
module rr_arb4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic [1:0] gnt_idx,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [1:0]  gnt_idx_q, gnt_idx_d;
  logic        gnt_valid_q, gnt_valid_d;
  logic        timeout_q, timeout_d;

  logic [1:0]  winner;
  logic [1:0]  cand;
  logic        owner_req;
  logic        at_limit;

  // Scan from the farthest offset back to ptr so the nearest requester wins.
  always_comb begin
    winner = ptr_q;
    cand   = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (req[cand]) begin
        winner = cand;
      end
    end
  end

  assign owner_req = req[gnt_idx_q];
  assign at_limit  = (hold_cnt_q == 8'(MAX_HOLD - 1));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d       = 4'b0001 << winner;
          gnt_idx_d   = winner;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = 8'd0;
          state_d     = GRANT;
        end else begin
          gnt_d       = 4'b0000;
          gnt_idx_d   = 2'd0;
          gnt_valid_d = 1'b0;
        end
      end

      GRANT: begin
        if (done || !owner_req || at_limit) begin
          gnt_d       = 4'b0000;
          gnt_idx_d   = 2'd0;
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_idx_q + 2'd1;
          state_d     = IDLE;
          // Flag only releases forced by the hold limit alone.
          timeout_d   = at_limit && !done && owner_req;
        end else begin
          hold_cnt_d  = hold_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      hold_cnt_q  <= 8'd0;
      gnt_q       <= 4'b0000;
      gnt_idx_q   <= 2'd0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;
  assign timeout   = timeout_q;

endmodule

// File: doc/rr_arb4.md
RR_ARB4 -- requirements
Module: rr_arb4

Interface
REQ-001 Parameter MAX_HOLD, default 8, maximum consecutive cycles one requester may hold a grant; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  request vector; bit i = requester i wants the resource.
REQ-005 done  input  1  current grant holder releases the resource; sampled only in GRANT.
REQ-006 gnt  output  4  registered grant; one-hot or all-zero; this is the one-hot source for the downstream 4->2 encoder.
REQ-007 gnt_valid  output  1  registered; 1 exactly when gnt is non-zero.
REQ-008 gnt_idx  output  2  registered binary index of the set gnt bit; 0 when gnt is all-zero.
REQ-009 timeout  output  1  registered one-cycle pulse marking a forced release.

Function
REQ-010 Two states, IDLE and GRANT; internal 2-bit priority pointer ptr and 8-bit hold counter hold_cnt.
REQ-011 IDLE, req==0 at edge: stay IDLE; gnt=0, gnt_valid=0, gnt_idx=0.
REQ-012 IDLE, req!=0 at edge: winner is first set bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4); on that edge gnt=one-hot(winner), gnt_idx=winner, gnt_valid=1, hold_cnt=0, go to GRANT.
REQ-013 Grant latency: req sampled at edge k in IDLE is visible on gnt immediately after edge k.
REQ-014 GRANT release conditions at an edge, any of: done=1; req[owner]=0; hold_cnt==MAX_HOLD-1.
REQ-015 On release: gnt=0, gnt_valid=0, gnt_idx=0, ptr=(owner+1) mod 4, state IDLE.
REQ-016 No release at edge: gnt/gnt_idx/gnt_valid unchanged, hold_cnt increments by 1.
REQ-017 Every release is followed by at least one IDLE cycle with gnt=0 (one-cycle bubble); no back-to-back grants.
REQ-018 timeout=1 for exactly the cycle after a release caused solely by hold_cnt==MAX_HOLD-1; else 0.
REQ-019 Simultaneous done=1 (or req[owner]=0) and hold_cnt==MAX_HOLD-1: normal release, timeout=0.
REQ-020 MAX_HOLD=1: every grant lasts exactly one cycle; timeout pulses if done=0 and req[owner]=1.
REQ-021 Changes to req bits other than the owner's have no effect during GRANT.
REQ-022 ptr wraps 3->0; arbitration search wraps modulo 4.
REQ-023 gnt shall never have more than one bit set in any cycle.
REQ-024 ptr changes only on release; IDLE with req==0 leaves ptr unchanged.

Reset
REQ-025 rst_n=0 immediately, without a clock edge: state=IDLE, ptr=0, hold_cnt=0, gnt=0, gnt_valid=0, gnt_idx=0, timeout=0.
REQ-026 Reset asserted mid-GRANT or mid-timeout pulse clears all outputs immediately; first edge after rst_n rises arbitrates with ptr=0.

Verification
REQ-027 After reset, req=4'b1111 held, done pulsed one cycle per grant -> grant order 4'b0001,4'b0010,4'b0100,4'b1000,4'b0001, gnt_idx 0,1,2,3,0, one zero cycle between grants.
REQ-028 MAX_HOLD=8, req=4'b0100 held, done=0 -> gnt=4'b0100 for 8 cycles, then gnt=0 and timeout=1 one cycle, then re-grant 4'b0100.
REQ-029 Owner 1 granted, req[1] dropped while req=4'b1001 -> gnt=0 next cycle, then gnt=4'b1000 (ptr=2 skips to 3).
REQ-030 done=1 on the same edge hold_cnt reaches MAX_HOLD-1 -> release with timeout=0.
REQ-031 rst_n pulled low asynchronously while gnt=4'b0010 -> gnt=0, gnt_valid=0, gnt_idx=0 before next edge; after release, req=4'b1010 -> gnt=4'b0010.
REQ-032 Every cycle of every test: gnt one-hot or zero, gnt_valid==|gnt, gnt_idx equals the binary encoding of gnt.
